// File: rtl/ps2_receiver_if.sv
// Decoded key-event bus from the PS/2 receiver to its consumer.
// The interface carries a valid/ready handshake plus the one-cycle error pulses.
interface ps2_receiver_if;
  logic [7:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       is_extended;
  logic       is_break;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (
    output code, code_valid, is_extended, is_break,
    output parity_err, frame_err, overrun,
    input  code_ready
  );

  modport slave (
    input  code, code_valid, is_extended, is_break,
    input  parity_err, frame_err, overrun,
    output code_ready
  );
endinterface

// File: rtl/ps2_receiver.sv
// Host-side PS/2 deserializer: synchronizes the device clock/data lines, rebuilds
// 11-bit frames, folds E0/F0 prefixes into flags and presents one key event at a time.
module ps2_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_receiver_if.master bus
);

  localparam int unsigned SS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SS-1:0]   r_clk_sync;
  logic [SS-1:0]   r_dat_sync;
  logic            r_clk_prev;
  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ext_pend;
  logic            r_brk_pend;
  logic [7:0]      r_code;
  logic            r_valid;
  logic            r_ext;
  logic            r_brk;
  logic            r_perr;
  logic            r_ferr;
  logic            r_ovr;

  logic w_clk_s;
  logic w_dat_s;
  logic w_fall;
  logic w_xfer;
  logic w_stop_eval;
  logic w_par_ok;
  logic w_frame_bad;
  logic w_par_bad;
  logic w_good;
  logic w_is_e0;
  logic w_is_f0;
  logic w_event;
  logic w_load;
  logic w_timeout;
  logic w_glitch;
  logic w_any_ferr;
  logic w_any_err;

  // Input synchronizers; reset to the idle-high line level so release cannot fake an edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SS-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SS-2:0], ps2_dat};
      r_clk_prev <= r_clk_sync[SS-1];
    end
  end

  assign w_clk_s = r_clk_sync[SS-1];
  assign w_dat_s = r_dat_sync[SS-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  // Frame evaluation, all qualified by the stop-bit edge.
  assign w_stop_eval = (r_state == S_STOP) & w_fall;
  assign w_par_ok    = ^{r_shift, r_parity};
  assign w_frame_bad = w_stop_eval & ~w_dat_s;
  assign w_par_bad   = w_stop_eval & w_dat_s & ~w_par_ok;
  assign w_good      = w_stop_eval & w_dat_s & w_par_ok;
  assign w_is_e0     = (r_shift == 8'hE0);
  assign w_is_f0     = (r_shift == 8'hF0);
  assign w_event     = w_good & ~w_is_e0 & ~w_is_f0;

  assign w_timeout  = (r_state != S_IDLE) & ~w_fall &
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_glitch   = (r_state == S_IDLE) & w_fall & w_dat_s;
  assign w_any_ferr = w_frame_bad | w_timeout | w_glitch;
  assign w_any_err  = w_any_ferr | w_par_bad;

  assign w_xfer = r_valid & bus.code_ready;
  assign w_load = w_event & (~r_valid | w_xfer);

  // Bit-level frame FSM with inactivity timeout; timeout overrides the state update.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall && !w_dat_s) begin
            r_state   <= S_DATA;
            r_bit_cnt <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_shift[r_bit_cnt] <= w_dat_s;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_parity <= w_dat_s;
            r_state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (r_state == S_IDLE || w_fall) begin
        r_to_cnt <= '0;
      end else if (w_timeout) begin
        r_to_cnt <= '0;
        r_state  <= S_IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Prefix folding, error pulses and the valid/ready output register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_code     <= 8'h00;
      r_valid    <= 1'b0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_perr <= w_par_bad;
      r_ferr <= w_any_ferr;
      r_ovr  <= w_event & ~w_load;

      if (w_any_err) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_good) begin
        if (w_is_e0) begin
          r_ext_pend <= 1'b1;
        end else if (w_is_f0) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end

      if (w_load) begin
        r_code  <= r_shift;
        r_ext   <= r_ext_pend;
        r_brk   <= r_brk_pend;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.code        = r_code;
  assign bus.code_valid  = r_valid;
  assign bus.is_extended = r_ext;
  assign bus.is_break    = r_brk;
  assign bus.parity_err  = r_perr;
  assign bus.frame_err   = r_ferr;
  assign bus.overrun     = r_ovr;

endmodule
